// File: rtl/divisor_programavel.sv
// ---------------------------------------------------------------------------
// divisor_programavel
//
// Multi-channel programmable clock-enable generator. Each channel divides
// clockPlaca by a runtime-loadable ratio D and produces a one-cycle tick
// enable (period D) plus a 50 %-duty square signal onda (period 2*D).
// The outputs are meant to be used as clock enables, not as derived clocks.
//
// Ports
//   clockPlaca  in   board clock, all state changes on its rising edge
//   reset       in   synchronous, active-high reset
//   habilita    in   global run; 0 freezes counters and onda
//   sincroniza  in   phase-align strobe; restarts every channel together
//   carrega     in   [CANAIS] per-channel divisor load strobe
//   divisores   in   [CANAIS*LARGURA] divisor inputs, channel i at
//                    [i*LARGURA +: LARGURA]
//   tick        out  [CANAIS] one-cycle enable pulse every D cycles
//   onda        out  [CANAIS] toggles on every tick
//   ativo       out  [CANAIS] 1 when the channel's divisor is nonzero
// ---------------------------------------------------------------------------
module divisor_programavel #(
    parameter int CANAIS    = 3,
    parameter int LARGURA   = 16,
    parameter int DIV_RESET = 1
) (
    input  logic                        clockPlaca,
    input  logic                        reset,
    input  logic                        habilita,
    input  logic                        sincroniza,
    input  logic [CANAIS-1:0]           carrega,
    input  logic [CANAIS*LARGURA-1:0]   divisores,
    output logic [CANAIS-1:0]           tick,
    output logic [CANAIS-1:0]           onda,
    output logic [CANAIS-1:0]           ativo
);

    localparam logic [LARGURA-1:0] DIV_INI = LARGURA'(DIV_RESET);
    localparam logic [LARGURA-1:0] UM      = LARGURA'(1);

    for (genvar g = 0; g < CANAIS; g++) begin : g_canal
        logic [LARGURA-1:0] div_reg;
        logic [LARGURA-1:0] cnt;
        logic               tick_reg;
        logic               onda_reg;
        logic               fim;

        // Terminal count. cnt never exceeds div_reg-1 because every divisor
        // change clears cnt, so an equality compare is sufficient.
        assign fim = (cnt == (div_reg - UM));

        always_ff @(posedge clockPlaca) begin
            if (reset) begin
                div_reg  <= DIV_INI;
                cnt      <= '0;
                tick_reg <= 1'b0;
                onda_reg <= 1'b0;
            end else if (sincroniza || carrega[g]) begin
                // A load always restarts the period, which also swallows a
                // tick that would have coincided with it.
                if (carrega[g]) begin
                    div_reg <= divisores[g*LARGURA +: LARGURA];
                end
                if (sincroniza) begin
                    onda_reg <= 1'b0;
                end
                cnt      <= '0;
                tick_reg <= 1'b0;
            end else if (habilita && (div_reg != '0)) begin
                if (fim) begin
                    cnt      <= '0;
                    tick_reg <= 1'b1;
                    onda_reg <= ~onda_reg;
                end else begin
                    cnt      <= cnt + UM;
                    tick_reg <= 1'b0;
                end
            end else begin
                tick_reg <= 1'b0;
            end
        end

        assign tick[g]  = tick_reg;
        assign onda[g]  = onda_reg;
        assign ativo[g] = (div_reg != '0);
    end

endmodule

// File: doc/divisor_programavel.md
# divisor_programavel

Multi-channel programmable clock-enable generator for the board clock domain. Each of `CANAIS` channels holds a runtime-loadable divide ratio and produces a one-cycle `tick` enable plus a 50 %-duty `onda` square signal, all synchronous to `clockPlaca`. Logic downstream uses these as clock enables for display multiplexing, 1 s and 0.5 s timebases, and similar, rather than as derived clocks. Unlike the fixed power-of-two ripple dividers, it supports arbitrary ratios, per-channel reload, global pause and phase alignment.

## Interface
- `CANAIS`, 3, number of independent channels (≥1)
- `LARGURA`, 16, width of divisor and counter per channel (≥2)
- `DIV_RESET`, 1, divisor value loaded into every channel on reset (0 ≤ value < 2^LARGURA)

- `clockPlaca`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `habilita`  in  1  global run; 0 = all counters and `onda` hold
- `sincroniza`  in  1  phase-align strobe; restarts all channels together
- `carrega`  in  CANAIS  per-channel load strobe; bit i latches channel i divisor
- `divisores`  in  CANAIS*LARGURA  divisor inputs; channel i at bits [i*LARGURA +: LARGURA]
- `tick`  out  CANAIS  one-cycle enable pulse, period D_i cycles
- `onda`  out  CANAIS  toggles on every tick, period 2·D_i cycles
- `ativo`  out  CANAIS  1 when the channel's registered divisor is nonzero

## Operation
- Per channel i: registered divisor `D`, counter `cnt` (LARGURA bits), and registered `tick` and `onda`. `ativo` = (D != 0), combinational from the register.
- Per-edge priority, highest first:
  1. `reset`: D←DIV_RESET, cnt←0, tick←0, onda←0.
  2. `sincroniza` and/or `carrega[i]`:
     - `carrega[i]`: D←divisores slice i.
     - `sincroniza`: onda←0 on all channels.
     - Either strobe: cnt←0, tick←0 on the affected channel(s).
     - Both in the same cycle: both effects apply.
     - `onda` is preserved on a load without `sincroniza`.
  3. `habilita`=1, D≠0, cnt==D−1: cnt←0, tick←1, onda←~onda.
  4. `habilita`=1, D≠0, otherwise: cnt←cnt+1, tick←0.
  5. `habilita`=0 or D=0: cnt and onda hold, tick←0.
- D=0: channel disabled; tick stays 0 and onda freezes at its current value.
- D=1: tick high on every enabled cycle; onda toggles every cycle.
- Ratios are exact for all D in 1..2^LARGURA−1. cnt never exceeds D−1 because a divisor change always clears cnt, so no wrap-around hazard exists.

## Timing
- Reset values: tick=0, onda=0, ativo=(DIV_RESET≠0).
- Edge numbering: edge 1 is the first edge with `reset` low and `habilita` high.
- With D loaded, tick is high during the cycle after edge D, then after edges 2D, 3D, and so on. Tick is exactly one cycle wide except when D=1.
- After `carrega` or `sincroniza` at edge k (habilita high from then on), the first tick follows edge k+D.
- A load coinciding with terminal count suppresses that tick; the new period starts from 0.
- Dropping `habilita` for N cycles stretches the tick interval by exactly N cycles. No tick is lost or duplicated.
- `reset` asserted mid-period: all outputs return to reset values on that edge.

## Test plan
- Reset with DIV_RESET=1, habilita=1: tick=all ones from the cycle after edge 1; onda alternates 1,0,1,… every cycle; ativo=all ones.
- Load D={5,3,0} into channels 0/1/2, then habilita=1:
  - ch0 ticks after edges 5, 10, 15; ch1 after edges 3, 6, 9.
  - ch2 has tick=0, onda=0, ativo=0 throughout.
  - ch0 onda has period 10.
- Ch0 D=4; drop habilita for 3 cycles after edge 2: the next tick follows edge 7 instead of edge 4, and onda holds during the pause.
- Ch0 D=6, pulse carrega[0] with divisor 2 exactly at terminal count: no tick on that edge; ticks then follow load edge +2, +4.
- Ch0 D=3, ch1 D=4 running out of phase; pulse sincroniza: both onda=0 and cnt=0, and both tick together after the strobe edge +12.
- Assert reset for one cycle in the middle of a D=7 period: outputs clear to reset values, and the period restarts at DIV_RESET.
